// File: rtl/count_event_queue_if.sv
// Valid/ready handshake carrying one count event from the queue to its reader.
interface count_event_queue_if;
    logic       event_valid_o;
    logic       event_ready_i;
    logic [7:0] event_count_o;
    logic       event_wrap_o;
    logic       event_thresh_o;

    modport master (
        output event_valid_o,
        output event_count_o,
        output event_wrap_o,
        output event_thresh_o,
        input  event_ready_i
    );

    modport slave (
        input  event_valid_o,
        input  event_count_o,
        input  event_wrap_o,
        input  event_thresh_o,
        output event_ready_i
    );
endinterface

// File: rtl/count_event_queue.sv
// Logs every change of an upstream 8-bit counter into a small circular FIFO
// drained over valid/ready; drops on a full FIFO are counted, never stalled.
module count_event_queue #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] THRESHOLD = 8'd200
) (
    input  logic                       clock_i,
    input  logic                       reset_ni,
    input  logic [7:0]                 count_i,
    input  logic                       clear_i,
    count_event_queue_if.master        evt,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic [7:0]                 drop_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // Entry layout: {wrap, thresh, count}
    logic [9:0]    mem_q [DEPTH];

    logic [7:0]    prev_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic          change;
    logic          valid;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [9:0]    payload;
    logic [9:0]    head;

    assign change  = (count_i != prev_q);
    assign valid   = (level_q != '0);
    assign full    = (level_q == FULL_LEVEL);
    assign pop     = valid && evt.event_ready_i;
    // A full FIFO still takes the push when the head leaves on the same edge.
    assign push_ok = change && (!full || pop);
    assign drop    = change && full && !pop;
    assign payload = {(prev_q == 8'hFF) && (count_i == 8'h00),
                      (count_i == THRESHOLD),
                      count_i};
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clear_i) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            prev_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            prev_q       <= count_i;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage carries no reset; stale entries are masked by the level counter.
    always_ff @(posedge clock_i) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= payload;
    end

    assign evt.event_valid_o  = valid;
    assign evt.event_count_o  = valid ? head[7:0] : 8'd0;
    assign evt.event_thresh_o = valid ? head[8]   : 1'b0;
    assign evt.event_wrap_o   = valid ? head[9]   : 1'b0;

    assign level_o      = level_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_count_q;
endmodule
